// File: rtl/wb_uart_cmd_master_pkg.sv
// rtl/wb_uart_cmd_master_pkg.sv - opcodes, status bytes and FSM states for the UART-to-Wishbone command master
package wb_uart_cmd_pkg;

    localparam logic [7:0] OP_WR     = 8'h57;
    localparam logic [7:0] OP_RD     = 8'h52;
    localparam logic [7:0] OP_WR_INC = 8'h77;
    localparam logic [7:0] OP_RD_INC = 8'h72;

    localparam logic [7:0] ST_OK  = 8'h4B;
    localparam logic [7:0] ST_ERR = 8'h45;
    localparam logic [7:0] ST_TMO = 8'h54;
    localparam logic [7:0] ST_BAD = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADR,
        GET_DAT,
        BUS_REQ,
        BUS_WAIT,
        TX_STATUS,
        TX_DATA
    } state_t;

    // Byte idx of a 32-bit word, idx 0 being the most significant byte
    function automatic logic [7:0] data_byte(input logic [31:0] d, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wb_uart_cmd_master_if.sv
// rtl/wb_uart_cmd_master_if.sv - pipelined Wishbone bus between the command master and the data bus slaves
interface wb_uart_cmd_master_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
    );
endinterface

// File: rtl/wb_uart_cmd_master_timer.sv
// rtl/wb_uart_cmd_master_timer.sv - loadable down-counter raising a one-cycle expire after LIMIT running cycles
module wb_uart_cmd_timer #(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expire
);
    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;

    // Reload to LIMIT on load, otherwise count down while running and stop at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= W'(LIMIT);
        end else if (i_load) begin
            r_cnt <= W'(LIMIT);
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    // A load in the same cycle restarts the window, so it masks the expiry
    assign o_expire = i_run & ~i_load & (r_cnt == W'(1));
endmodule

// File: rtl/wb_uart_cmd_master.sv
// rtl/wb_uart_cmd_master.sv - UART byte-stream command parser issuing single Wishbone accesses (option: WB_UART_CMD_AUTOINC_EN)
module wb_uart_cmd_master
    import wb_uart_cmd_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int RX_TIMEOUT  = 200000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [7:0]                  rx_byte_i,
    input  logic                        rx_valid_i,
    output logic [7:0]                  tx_byte_o,
    output logic                        tx_valid_o,
    input  logic                        tx_ready_i,
    wb_uart_cmd_master_if.master        wb,
    output logic                        busy_o
);
    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [7:0]  r_status;
    logic [7:0]  r_tx_byte;
    logic        r_tx_valid;
    logic        r_cyc;
    logic        r_stb;

    logic        w_in_frame;
    logic        w_on_bus;
    logic        w_accept;
    logic        w_bus_hit;
    logic        w_bus_done;
    logic        w_rx_expire;
    logic        w_ack_expire;
    logic [7:0]  w_bus_status;
    logic [31:0] w_shift_next;

    assign w_in_frame   = (r_state == GET_ADR) || (r_state == GET_DAT);
    assign w_on_bus     = (r_state == BUS_REQ) || (r_state == BUS_WAIT);
    assign w_accept     = (r_state == BUS_REQ) && !wb.wb_stall_i;
    // A response is only meaningful once the strobe has been (or is being) accepted
    assign w_bus_hit    = (r_state == BUS_WAIT) || w_accept;
    assign w_bus_done   = (w_bus_hit && (wb.wb_ack_i || wb.wb_err_i)) || w_ack_expire;
    assign w_bus_status = (w_bus_hit && wb.wb_err_i) ? ST_ERR :
                          (w_bus_hit && wb.wb_ack_i) ? ST_OK  : ST_TMO;
    assign w_shift_next = {r_shift, rx_byte_i};

    // Inter-byte gap: restarts on each received byte, runs only inside a frame
    wb_uart_cmd_timer #(.LIMIT(RX_TIMEOUT)) u_rx_timer (
        .i_clk    (clk_i),
        .i_rst_n  (reset_i),
        .i_load   (rx_valid_i || !w_in_frame),
        .i_run    (w_in_frame),
        .o_expire (w_rx_expire)
    );

    // Bus watchdog: bounds stall in BUS_REQ, then restarts at accept to bound the wait for ack/err
    wb_uart_cmd_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_timer (
        .i_clk    (clk_i),
        .i_rst_n  (reset_i),
        .i_load   (w_accept || !w_on_bus),
        .i_run    (w_on_bus),
        .o_expire (w_ack_expire)
    );

    // Command FSM: parse frame, run one bus access, return status and read data
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_cnt      <= 2'd0;
            r_shift    <= '0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_status   <= 8'h00;
            r_tx_byte  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
        end else if (w_bus_done) begin
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_status   <= w_bus_status;
            r_tx_byte  <= w_bus_status;
            r_tx_valid <= 1'b1;
            r_state    <= TX_STATUS;
            if (w_bus_status == ST_OK) begin
                if (!r_we) begin
                    r_dat <= wb.wb_dat_i;
                end
`ifdef WB_UART_CMD_AUTOINC_EN
                r_adr <= r_adr + 32'd4;
`endif
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_valid_i) begin
                        r_cnt <= 2'd0;
                        case (rx_byte_i)
                            OP_WR, OP_RD: begin
                                r_we    <= (rx_byte_i == OP_WR);
                                r_state <= GET_ADR;
                            end
`ifdef WB_UART_CMD_AUTOINC_EN
                            OP_WR_INC: begin
                                r_we    <= 1'b1;
                                r_state <= GET_DAT;
                            end
                            OP_RD_INC: begin
                                r_we    <= 1'b0;
                                r_cyc   <= 1'b1;
                                r_stb   <= 1'b1;
                                r_state <= BUS_REQ;
                            end
`endif
                            default: begin
                                r_status   <= ST_BAD;
                                r_tx_byte  <= ST_BAD;
                                r_tx_valid <= 1'b1;
                                r_state    <= TX_STATUS;
                            end
                        endcase
                    end
                end
                GET_ADR: begin
                    if (w_rx_expire) begin
                        r_state <= IDLE;
                    end else if (rx_valid_i) begin
                        r_shift <= w_shift_next[23:0];
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_adr <= w_shift_next;
                            if (r_we) begin
                                r_state <= GET_DAT;
                            end else begin
                                r_cyc   <= 1'b1;
                                r_stb   <= 1'b1;
                                r_state <= BUS_REQ;
                            end
                        end
                    end
                end
                GET_DAT: begin
                    if (w_rx_expire) begin
                        r_state <= IDLE;
                    end else if (rx_valid_i) begin
                        r_shift <= w_shift_next[23:0];
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_dat   <= w_shift_next;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_state <= BUS_REQ;
                        end
                    end
                end
                BUS_REQ: begin
                    if (w_accept) begin
                        r_stb   <= 1'b0;
                        r_state <= BUS_WAIT;
                    end
                end
                BUS_WAIT: begin
                    r_state <= BUS_WAIT;
                end
                TX_STATUS: begin
                    if (tx_ready_i) begin
                        if ((r_status == ST_OK) && !r_we) begin
                            r_cnt     <= 2'd0;
                            r_tx_byte <= data_byte(r_dat, 2'd0);
                            r_state   <= TX_DATA;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
                end
                TX_DATA: begin
                    if (tx_ready_i) begin
                        if (r_cnt == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_cnt     <= r_cnt + 2'd1;
                            r_tx_byte <= data_byte(r_dat, r_cnt + 2'd1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wb.wb_cyc_o = r_cyc;
    assign wb.wb_stb_o = r_stb;
    assign wb.wb_we_o  = r_we;
    assign wb.wb_adr_o = r_adr;
    assign wb.wb_dat_o = r_dat;
    assign wb.wb_sel_o = 4'hF;
    assign tx_byte_o   = r_tx_byte;
    assign tx_valid_o  = r_tx_valid;
    assign busy_o      = (r_state != IDLE);
endmodule

// File: tb/tb_wb_uart_cmd_master.sv
// tb/tb_wb_uart_cmd_master.sv - bench for wb_uart_cmd_master with a frame-level reference model (option: WB_UART_CMD_AUTOINC_EN)
`timescale 1ns/1ps
module tb_wb_uart_cmd_master;
    localparam int ACK_TMO = 16;
    localparam int RX_TMO  = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    wb_uart_cmd_master_if wb_bus ();

    wb_uart_cmd_master #(.ACK_TIMEOUT(ACK_TMO), .RX_TIMEOUT(RX_TMO)) dut (
        .clk_i      (clk),
        .reset_i    (rst_n),
        .rx_byte_i  (rx_byte),
        .rx_valid_i (rx_valid),
        .tx_byte_o  (tx_byte),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .wb         (wb_bus),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int cycle_no = 0;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    // slave behaviour knobs, set by the main sequence
    int          cfg_stall = 0, cfg_lat = 1, cfg_resp = 0, cfg_gap = 0;
    logic [31:0] cfg_rdata = 32'h0;

    // observations from the slave / tx monitors
    int          n_acc = 0, stb_cycles = 0, cyc_cycles = 0;
    int          resp_cycle = -1, cyc_rise = -1, txv_rise = -1, last_rx_cycle = -1;
    logic [31:0] acc_adr, acc_dat;
    logic        acc_we;
    logic [3:0]  acc_sel;
    logic [7:0]  tx_q[$];

    int n_total = 0, n_pass = 0, n_fail = 0;
    logic [31:0] model_ptr = 32'h0;

    // Wishbone slave: programmable stall, response latency and response kind
    initial begin
        int  s_left, s_cnt;
        bit  s_pend, prev_cyc;
        s_left = 0; s_cnt = 0; s_pend = 0; prev_cyc = 0;
        wb_bus.wb_stall_i = 1'b0; wb_bus.wb_ack_i = 1'b0; wb_bus.wb_err_i = 1'b0; wb_bus.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            wb_bus.wb_ack_i = 1'b0; wb_bus.wb_err_i = 1'b0; wb_bus.wb_stall_i = 1'b0;
            wb_bus.wb_dat_i = $urandom;
            if (wb_bus.wb_cyc_o !== 1'b1) begin
                s_pend = 0; s_left = cfg_stall;
            end else begin
                cyc_cycles++;
                if (!prev_cyc) cyc_rise = cycle_no;
                if (wb_bus.wb_stb_o) begin
                    stb_cycles++;
                    if (s_left > 0) begin
                        wb_bus.wb_stall_i = 1'b1; s_left--;
                    end else begin
                        n_acc++;
                        acc_adr = wb_bus.wb_adr_o; acc_we = wb_bus.wb_we_o;
                        acc_dat = wb_bus.wb_dat_o; acc_sel = wb_bus.wb_sel_o;
                        s_pend = 1; s_cnt = cfg_lat;
                    end
                end
                if (s_pend) begin
                    if (s_cnt == 0) begin
                        if (cfg_resp != 2) begin
                            s_pend = 0; resp_cycle = cycle_no;
                            wb_bus.wb_ack_i = (cfg_resp == 0 || cfg_resp == 3);
                            wb_bus.wb_err_i = (cfg_resp == 1 || cfg_resp == 3);
                            if (cfg_resp == 0) wb_bus.wb_dat_i = cfg_rdata;
                        end
                    end else begin
                        s_cnt--;
                    end
                end
            end
            prev_cyc = (wb_bus.wb_cyc_o === 1'b1);
        end
    end

    // Transmit sink: holds ready low cfg_gap cycles per byte, logs every accepted byte
    initial begin
        int gap_cnt;
        bit prev_txv;
        gap_cnt = 0; prev_txv = 0; tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_valid === 1'b1 && !prev_txv) txv_rise = cycle_no;
            prev_txv = (tx_valid === 1'b1);
            tx_ready = 1'b0;
            if (tx_valid === 1'b1) begin
                if (gap_cnt < cfg_gap) gap_cnt++;
                else begin tx_ready = 1'b1; tx_q.push_back(tx_byte); gap_cnt = 0; end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk); rx_byte = b; rx_valid = 1'b1; last_rx_cycle = cycle_no;
        repeat (gap) begin @(negedge clk); rx_valid = 1'b0; end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || tx_valid !== 1'b0) && k < 3000) begin @(negedge clk); k++; end
        chk({tag, "_idle_bound"}, (k < 3000), 1);
    endtask

    function automatic logic [7:0] status_of(input int resp);
        case (resp)
            0:       return 8'h4B;
            2:       return 8'h54;
            default: return 8'h45;
        endcase
    endfunction

    // Frame-level model: which bus access (if any) and which reply bytes a frame must produce
    task automatic run_frame(input string tag, input logic [7:0] op, input logic [31:0] adr,
                             input logic [31:0] dat, input int gap);
        logic [7:0]  frame[$];
        logic [7:0]  exp_tx[$];
        logic [7:0]  st, ob;
        logic [31:0] exp_adr;
        bit          known, has_adr, is_wr;
        int          acc0, tx0;
        known = (op == 8'h57) || (op == 8'h52);
        has_adr = known;
        is_wr = (op == 8'h57);
`ifdef WB_UART_CMD_AUTOINC_EN
        if (op == 8'h77 || op == 8'h72) begin known = 1; is_wr = (op == 8'h77); end
`endif
        frame.push_back(op);
        if (has_adr) for (int i = 3; i >= 0; i--) frame.push_back(adr[8*i +: 8]);
        if (known && is_wr) for (int i = 3; i >= 0; i--) frame.push_back(dat[8*i +: 8]);
        exp_adr = has_adr ? adr : model_ptr;
        if (!known) begin
            exp_tx.push_back(8'h3F);
        end else begin
            st = status_of(cfg_resp);
            exp_tx.push_back(st);
            if (st == 8'h4B && !is_wr) for (int i = 3; i >= 0; i--) exp_tx.push_back(cfg_rdata[8*i +: 8]);
            model_ptr = exp_adr;
`ifdef WB_UART_CMD_AUTOINC_EN
            if (st == 8'h4B) model_ptr = exp_adr + 32'd4;
`endif
        end
        acc0 = n_acc; tx0 = tx_q.size();
        foreach (frame[i]) send_byte(frame[i], (i == frame.size() - 1) ? 0 : gap);
        @(negedge clk); rx_valid = 1'b0;
        wait_idle(tag);
        chk({tag, "_nacc"}, n_acc - acc0, known ? 1 : 0);
        if (known) begin
            chk({tag, "_adr"}, acc_adr, exp_adr);
            chk({tag, "_we"}, acc_we, is_wr);
            chk({tag, "_sel"}, acc_sel, 4'hF);
            if (is_wr) chk({tag, "_wdat"}, acc_dat, dat);
        end
        chk({tag, "_ntx"}, tx_q.size() - tx0, exp_tx.size());
        foreach (exp_tx[i]) begin
            ob = 'x;
            if (tx0 + i < tx_q.size()) ob = tx_q[tx0 + i];
            chk($sformatf("%s_tx%0d", tag, i), ob, exp_tx[i]);
        end
    endtask

    initial begin
        int          stb0, cyc0, acc0, tx0, k;
        logic [7:0]  op;
        logic [31:0] a, d;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cyc", wb_bus.wb_cyc_o, 0);
        chk("rst_stb", wb_bus.wb_stb_o, 0);
        chk("rst_we", wb_bus.wb_we_o, 0);
        chk("rst_adr", wb_bus.wb_adr_o, 0);
        chk("rst_dat", wb_bus.wb_dat_o, 0);
        chk("rst_sel", wb_bus.wb_sel_o, 4'hF);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txb", tx_byte, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single write, ack one cycle after accept
        cfg_stall = 0; cfg_lat = 1; cfg_resp = 0; cfg_gap = 0;
        stb0 = stb_cycles; cyc0 = cyc_cycles;
        run_frame("wr", 8'h57, 32'h1000_8020, 32'h0000_0001, 0);
        chk("wr_stb_cycles", stb_cycles - stb0, 1);
        chk("wr_cyc_cycles", cyc_cycles - cyc0, 2);
        chk("wr_req_latency", cyc_rise, last_rx_cycle + 1);
        chk("wr_tx_latency", txv_rise, resp_cycle + 1);

        // read with slow transmitter
        cfg_rdata = 32'hDEAD_BEEF; cfg_gap = 5;
        run_frame("rd", 8'h52, 32'h0000_0004, 32'h0, 1);
        chk("rd_tx_latency", txv_rise, resp_cycle + 1);

        // stall 3 cycles, then error 2 cycles after accept
        cfg_stall = 3; cfg_lat = 2; cfg_resp = 1; cfg_gap = 0;
        stb0 = stb_cycles; cyc0 = cyc_cycles;
        run_frame("stall_err", 8'h52, $urandom, 32'h0, 0);
        chk("stall_err_stb_cycles", stb_cycles - stb0, 4);
        chk("stall_err_cyc_cycles", cyc_cycles - cyc0, 6);

        // no response: watchdog ends the access
        cfg_stall = 0; cfg_lat = 0; cfg_resp = 2;
        stb0 = stb_cycles; cyc0 = cyc_cycles;
        run_frame("tmo", 8'h52, $urandom, 32'h0, 0);
        chk("tmo_stb_cycles", stb_cycles - stb0, 1);
        chk("tmo_cyc_cycles", cyc_cycles - cyc0, ACK_TMO + 1);
        cfg_resp = 0; cfg_lat = 1; cfg_rdata = $urandom;
        run_frame("after_tmo", 8'h52, $urandom, 32'h0, 0);

        // unknown opcodes
        run_frame("bad00", 8'h00, 32'h0, 32'h0, 0);
        do op = 8'($urandom); while (op == 8'h57 || op == 8'h52 || op == 8'h77 || op == 8'h72);
        run_frame("bad_rand", op, 32'h0, 32'h0, 0);

        // truncated frame followed by silence
        acc0 = n_acc; tx0 = tx_q.size();
        send_byte(8'h52, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        @(negedge clk); rx_valid = 1'b0;
        repeat (RX_TMO - 1) @(negedge clk);
        chk("rxtmo_busy_before", busy, 1);
        @(negedge clk);
        chk("rxtmo_busy_after", busy, 0);
        repeat (5) @(negedge clk);
        chk("rxtmo_nacc", n_acc - acc0, 0);
        chk("rxtmo_ntx", tx_q.size() - tx0, 0);

        // randomized frames against the model
        for (int n = 0; n < 8; n++) begin
            k = $urandom_range(0, 9);
            op = (k < 4) ? 8'h57 : (k < 8) ? 8'h52 : (k == 8) ? 8'h72 : 8'h77;
            cfg_resp = $urandom_range(0, 3); cfg_lat = $urandom_range(0, 3);
            cfg_stall = $urandom_range(0, 2); cfg_gap = $urandom_range(0, 2);
            cfg_rdata = $urandom; a = $urandom; d = $urandom;
            run_frame($sformatf("rnd%0d", n), op, a, d, $urandom_range(0, 2));
        end

        // address reuse after a read at 0x100
        cfg_resp = 0; cfg_lat = 1; cfg_stall = 0; cfg_gap = 0; cfg_rdata = $urandom;
        run_frame("inc_base", 8'h52, 32'h0000_0100, 32'h0, 0);
        cfg_rdata = $urandom;
        run_frame("inc_r", 8'h72, 32'h0, 32'h0, 0);

        // asynchronous reset while waiting for the slave
        cfg_resp = 2;
        send_byte(8'h52, 0);
        for (int i = 3; i >= 0; i--) send_byte(8'h00, 0);
        @(negedge clk); rx_valid = 1'b0;
        k = 0;
        while (!(wb_bus.wb_cyc_o === 1'b1 && wb_bus.wb_stb_o === 1'b0) && k < 100) begin @(negedge clk); k++; end
        chk("arst_reached_wait", wb_bus.wb_cyc_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", wb_bus.wb_cyc_o, 0);
        chk("arst_stb", wb_bus.wb_stb_o, 0);
        chk("arst_txv", tx_valid, 0);
        chk("arst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 32'h0;
        cfg_resp = 0; cfg_rdata = $urandom;
        repeat (2) @(negedge clk);
        run_frame("after_arst", 8'h52, $urandom, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wb_uart_cmd_master.md
Name: wb_uart_cmd_master

Overview:
- Wishbone initiator driven by a byte stream from the UART receive side: rx_byte/rx_irq-style input.
- Parses fixed-format read/write command frames and issues single 32-bit transactions onto the data bus slave ports.
- Returns status and read data as bytes through a valid/ready transmit handshake.
- Acts as a debug/test bridge, so a host can peek and poke memory, mtime, GPIO and loader registers without the core.

Parameters:
- ACK_TIMEOUT, 255: cycles allowed from stb accepted to ack/err before the bus access is aborted.
- RX_TIMEOUT, 200000: idle cycles allowed between bytes of one frame before the parser resets. This is 10 ms at 20 MHz.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- rx_byte_i  in  8  received byte, valid when rx_valid_i=1
- rx_valid_i  in  1  single-cycle strobe per received byte
- tx_byte_o  out  8  byte to transmit
- tx_valid_o  out  1  tx_byte_o valid; held until tx_ready_i
- tx_ready_i  in  1  transmitter accepts byte when tx_valid_o & tx_ready_i
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe (pipelined)
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte selects; always 4'hF
- wb_stall_i  in  1  slave stall
- wb_ack_i  in  1  slave ack
- wb_err_i  in  1  slave error
- wb_dat_i  in  32  read data
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_i=0): state=IDLE; cyc/stb/we/tx_valid/busy=0; adr/dat/tx_byte=0; sel=4'hF. Reset mid-transaction drops cyc/stb immediately.
- Frame formats (multi-byte fields MSB first):
  - Write: 0x57 ('W'), A3 A2 A1 A0, D3 D2 D1 D0.
  - Read: 0x52 ('R'), A3..A0.
- IDLE, on rx_valid_i:
  - Opcode 'W' or 'R': latch we and go to GET_ADR with byte count 0.
  - Any other byte: go to TX_STATUS with byte 0x3F ('?').
- GET_ADR: shift each byte into the address register. After the 4th byte, go to GET_DAT if we=1, else BUS_REQ.
- GET_DAT: shift 4 bytes into the data register, then go to BUS_REQ.
- Inter-byte timeout: in GET_ADR/GET_DAT, a counter clears on each rx_valid_i. When it reaches RX_TIMEOUT, return to IDLE silently; no response is sent and partial fields are discarded.
- BUS_REQ:
  - cyc=stb=1 with adr/we/dat driven.
  - The cycle where stb & ~stall_i is the accept: next cycle stb=0, cyc stays 1, go to BUS_WAIT, ack counter cleared.
  - If ack/err arrives in the same cycle as the accept, it is handled as in BUS_WAIT.
- BUS_WAIT:
  - ack_i: cyc=0; latch dat_i into the data register if read; status 0x4B ('K').
  - err_i: cyc=0; status 0x45 ('E'). If ack and err arrive together, err wins.
  - ACK_TIMEOUT reached: cyc=0; status 0x54 ('T').
  - Stall time in BUS_REQ is also bounded by ACK_TIMEOUT, giving status 'T' with cyc/stb dropped.
- TX_STATUS:
  - tx_valid=1 with the status byte, held until tx_ready_i.
  - Then go to TX_DATA if read and status='K', else IDLE.
- TX_DATA: send the 4 data bytes MSB first, each under the same handshake, then go to IDLE.
- rx_valid_i outside IDLE/GET_ADR/GET_DAT: the byte is dropped.
- Latency: BUS_REQ is entered the cycle after the last frame byte. tx_valid rises the cycle after the terminating ack/err/timeout.

Optional Feature:
- Macro: WB_UART_CMD_AUTOINC_EN.
- Defined:
  - After every access ending in 'K', the address register is incremented by 4 (wraps at 2^32).
  - Extra opcodes 0x77 ('w') and 0x72 ('r') skip GET_ADR and reuse the current address. 'w' is followed by 4 data bytes.
- Undefined: 'w' and 'r' are unknown opcodes (respond '?'), and the address is never modified after an access.

Decomposition:
- Package wb_uart_cmd_pkg holds:
  - Opcode constants: OP_WR, OP_RD, OP_WR_INC, OP_RD_INC.
  - Status bytes: ST_OK, ST_ERR, ST_TMO, ST_BAD.
  - State encoding: IDLE, GET_ADR, GET_DAT, BUS_REQ, BUS_WAIT, TX_STATUS, TX_DATA.
- One natural sub-module, wb_uart_cmd_timer:
  - Loadable down-counter with clear and expire pulse.
  - Instantiated twice: once for the RX timeout, once for the ACK timeout.

Test Plan:
- Write: send 57 10 00 80 20 00 00 00 01, slave acks 1 cycle after accept -> one cycle with cyc=stb=we=1, adr=0x10008020, dat=0x00000001, sel=F; tx bytes 4B.
- Read: send 52 00 00 00 04, slave returns 0xDEADBEEF -> we=0, adr=0x4; tx 4B DE AD BE EF. Hold tx_ready_i low 5 cycles per byte -> no byte lost or repeated.
- Stall then err: stall_i high 3 cycles after stb, err_i 2 cycles after accept -> stb held 4 cycles total; tx 45; no data bytes, even for a read.
- Timeout: slave never acks, ACK_TIMEOUT=16 -> cyc drops 16 cycles after accept; tx 54; then a new 'R' frame completes normally.
- Protocol errors:
  - Byte 0x00 in IDLE -> tx 3F.
  - 52 00 00 followed by silence > RX_TIMEOUT -> no tx, busy_o falls, no bus cycle.
- Async reset asserted in BUS_WAIT -> cyc/stb/tx_valid=0 immediately. With WB_UART_CMD_AUTOINC_EN, 'r' after a read at 0x100 -> adr=0x104.
